// File: rtl/cook_time_ctrl.sv
// Set-and-countdown controller for the egg-timer: edge-detected buttons set the time,
// and start/pause/resume/clear drive a 1 Hz countdown. Optional hold-to-repeat for min/sec under AUTO_REPEAT_EN.
module cook_time_ctrl #(
    parameter int MAX_MIN     = 5,
    parameter int SEC_STEP    = 5,
    parameter int REPEAT_DLY  = 50000000,
    parameter int REPEAT_RATE = 12500000
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       enable,
    input  logic       min,
    input  logic       sec,
    input  logic       start,
    input  logic       clear,
    input  logic       tick,
    output logic [5:0] minutes,
    output logic [5:0] seconds,
    output logic       running,
    output logic       done
);

    typedef enum logic [1:0] {S_SET, S_RUN, S_PAUSE, S_DONE} state_t;

    state_t     state, state_nx;
    logic [5:0] min_nx, sec_nx;
    logic       min_q, sec_q, start_q, clear_q;
    logic       min_press, sec_press, start_press, clear_press;
    logic       min_act, sec_act;
    logic [6:0] sec_sum;
    logic       sec_carry;

    // Minute field arithmetic modulo MAX_MIN+1; add is at most 2 (button plus seconds carry).
    function automatic logic [5:0] wrap_min(input logic [5:0] m, input logic [1:0] add);
        logic [6:0] sum;
        sum = {1'b0, m} + {5'd0, add};
        if (sum > 7'(MAX_MIN))
            sum = sum - 7'(MAX_MIN + 1);
        return sum[5:0];
    endfunction

    // Edge registers track the buttons even while disabled, so no press is replayed later.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            min_q   <= 1'b0;
            sec_q   <= 1'b0;
            start_q <= 1'b0;
            clear_q <= 1'b0;
        end else begin
            min_q   <= min;
            sec_q   <= sec;
            start_q <= start;
            clear_q <= clear;
        end
    end

    assign min_press   = min & ~min_q;
    assign sec_press   = sec & ~sec_q;
    assign start_press = start & ~start_q;
    assign clear_press = clear & ~clear_q;

`ifdef AUTO_REPEAT_EN
    localparam logic [25:0] RPT_LAST   = 26'(REPEAT_DLY - 1);
    localparam logic [25:0] RPT_RELOAD = 26'(REPEAT_DLY - REPEAT_RATE);

    logic [25:0] min_cnt, sec_cnt;
    logic        min_held, sec_held;

    assign min_held = min & min_q & enable & (state == S_SET);
    assign sec_held = sec & sec_q & enable & (state == S_SET);

    // After the initial delay the counter reloads so the next repeat lands REPEAT_RATE later.
    function automatic logic [25:0] rpt_next(input logic held, input logic [25:0] cnt);
        if (!held)
            return 26'd0;
        else if (cnt == RPT_LAST)
            return RPT_RELOAD;
        else
            return cnt + 26'd1;
    endfunction

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            min_cnt <= 26'd0;
            sec_cnt <= 26'd0;
        end else begin
            min_cnt <= rpt_next(min_held, min_cnt);
            sec_cnt <= rpt_next(sec_held, sec_cnt);
        end
    end

    assign min_act = min_press | (min_held & (min_cnt == RPT_LAST));
    assign sec_act = sec_press | (sec_held & (sec_cnt == RPT_LAST));
`else
    logic unused_repeat_params;
    assign unused_repeat_params = ^{26'(REPEAT_DLY), 26'(REPEAT_RATE)};
    assign min_act = min_press;
    assign sec_act = sec_press;
`endif

    assign sec_sum   = {1'b0, seconds} + 7'(SEC_STEP);
    assign sec_carry = sec_act & (sec_sum >= 7'd60);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state   <= S_SET;
            minutes <= 6'd0;
            seconds <= 6'd0;
        end else begin
            state   <= state_nx;
            minutes <= min_nx;
            seconds <= sec_nx;
        end
    end

    // Priority: clear > start > tick > min/sec.
    always_comb begin
        state_nx = state;
        min_nx   = minutes;
        sec_nx   = seconds;
        if (clear_press) begin
            state_nx = S_SET;
            min_nx   = 6'd0;
            sec_nx   = 6'd0;
        end else if (enable) begin
            case (state)
                S_SET: begin
                    if (start_press) begin
                        if (minutes != 6'd0 || seconds != 6'd0)
                            state_nx = S_RUN;
                    end else begin
                        if (sec_act)
                            sec_nx = sec_carry ? 6'd0 : sec_sum[5:0];
                        min_nx = wrap_min(minutes, {1'b0, min_act} + {1'b0, sec_carry});
                    end
                end
                S_RUN: begin
                    if (start_press) begin
                        state_nx = S_PAUSE;
                    end else if (tick) begin
                        if (seconds != 6'd0) begin
                            sec_nx = seconds - 6'd1;
                            if (seconds == 6'd1 && minutes == 6'd0)
                                state_nx = S_DONE;
                        end else if (minutes != 6'd0) begin
                            sec_nx = 6'd59;
                            min_nx = minutes - 6'd1;
                        end else begin
                            state_nx = S_DONE;
                        end
                    end
                end
                S_PAUSE: begin
                    if (start_press)
                        state_nx = S_RUN;
                end
                default: ;
            endcase
        end
    end

    assign running = (state == S_RUN);
    assign done    = (state == S_DONE);

endmodule
